// File: rtl/dma_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// dma_signals : arbiter state encoding, default addresses, dispatch helper
// rev 1.0
// ============================================================================
package dma_signals;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HALT   = 3'd1,
      S_ALIGN  = 3'd2,
      S_OAM_RD = 3'd3,
      S_OAM_WR = 3'd4,
      S_DMC_RD = 3'd5
   } state_type;

   localparam logic [15:0] OAM_TRIG_ADDR = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

   // DMA reads must land on get cycles; a put cycle in between is spent as a dummy read.
   function automatic state_type dispatch(input logic dmc, input logic oam, input logic next_get);
      if (dmc && next_get)
         return S_DMC_RD;
      else if (oam)
         return next_get ? S_OAM_RD : S_ALIGN;
      else if (dmc)
         return S_ALIGN;
      else
         return S_IDLE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dma_arbiter_cycle_timer.sv
`default_nettype none
// ============================================================================
// cycle_timer : CPU cycle strobe and get/put phase from the system clock
// rev 1.0
// ============================================================================
module cycle_timer #(
   parameter int P_TICKS = 12
) (
   input  logic clock,
   input  logic reset,
   output logic cyc,
   output logic put
);

   localparam int            TW   = (P_TICKS > 1) ? $clog2(P_TICKS) : 1;
   localparam logic [TW-1:0] LAST = TW'(P_TICKS - 1);

   logic [TW-1:0] tick;

   assign cyc = (tick == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick <= '0;
         put  <= 1'b0;
      end else if (cyc) begin
         tick <= '0;
         put  <= ~put;
      end else begin
         tick <= tick + TW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
// dma_arbiter : stalls the core and sequences OAM sprite DMA and DMC fetches
// rev 1.0
// ============================================================================
module dma_arbiter
   import dma_signals::*;
#(
   parameter int          P_TICKS    = 12,
   parameter logic [15:0] P_OAM_TRIG = OAM_TRIG_ADDR,
   parameter logic [15:0] P_OAM_DATA = OAM_DATA_ADDR
) (
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic [15:0] I_cpu_addr,
   input  logic [7:0]  I_cpu_wr_data,
   input  logic        I_cpu_rdwr,
   input  logic [7:0]  I_rd_data,
   input  logic        I_dmc_req,
   input  logic [15:0] I_dmc_addr,
   output logic [15:0] O_addr,
   output logic [7:0]  O_wr_data,
   output logic        O_rdwr,
   output logic        O_cpu_ready,
   output logic [7:0]  O_dmc_data,
   output logic        O_dmc_ack
);

   logic      cyc;
   logic      put;
   state_type state;
   state_type state_nx;
   logic [7:0] page;
   logic [7:0] idx;
   logic [7:0] latch;
   logic      oam_pend;
   logic      dmc_pend;
   logic      trig_write;
   logic      dmc_now;

   cycle_timer #(.P_TICKS(P_TICKS)) u_timer (
      .clock (I_clock),
      .reset (I_reset),
      .cyc   (cyc),
      .put   (put)
   );

   assign trig_write = (state == S_IDLE) && !I_cpu_rdwr && (I_cpu_addr == P_OAM_TRIG);
   // A request raised in the deciding cycle counts as already pending.
   assign dmc_now    = dmc_pend | I_dmc_req;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:            if (trig_write || dmc_now) state_nx = S_HALT;
         S_HALT, S_ALIGN:   state_nx = dispatch(dmc_now, oam_pend, put);
         S_OAM_RD:          state_nx = S_OAM_WR;
         S_OAM_WR: begin
            if (dmc_now)
               state_nx = S_DMC_RD;
            else if (oam_pend && (idx != 8'hFF))
               state_nx = S_OAM_RD;
            else
               state_nx = S_IDLE;
         end
         S_DMC_RD:          state_nx = oam_pend ? S_ALIGN : S_IDLE;
         default:           state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge I_clock or posedge I_reset) begin
      if (I_reset) begin
         state       <= S_IDLE;
         page        <= 8'h00;
         idx         <= 8'h00;
         latch       <= 8'h00;
         oam_pend    <= 1'b0;
         dmc_pend    <= 1'b0;
         O_cpu_ready <= 1'b1;
         O_dmc_data  <= 8'h00;
         O_dmc_ack   <= 1'b0;
      end else begin
         O_dmc_ack <= 1'b0;
         if (cyc) begin
            state       <= state_nx;
            O_cpu_ready <= (state_nx == S_IDLE);
            case (state)
               S_IDLE: begin
                  if (trig_write) begin
                     page     <= I_cpu_wr_data;
                     oam_pend <= 1'b1;
                  end
               end
               S_OAM_RD: latch <= I_rd_data;
               S_OAM_WR: begin
                  idx <= idx + 8'd1;
                  if (idx == 8'hFF) oam_pend <= 1'b0;
               end
               S_DMC_RD: begin
                  O_dmc_data <= I_rd_data;
                  O_dmc_ack  <= 1'b1;
               end
               default: ;
            endcase
            // The request is still held during the fetch; do not re-arm on it.
            if (state == S_DMC_RD)
               dmc_pend <= 1'b0;
            else if (I_dmc_req)
               dmc_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      O_addr    = I_cpu_addr;
      O_wr_data = I_cpu_wr_data;
      O_rdwr    = I_cpu_rdwr;
      case (state)
         S_HALT, S_ALIGN: begin
            O_wr_data = 8'h00;
            O_rdwr    = 1'b1;
         end
         S_OAM_RD: begin
            O_addr    = {page, idx};
            O_wr_data = 8'h00;
            O_rdwr    = 1'b1;
         end
         S_OAM_WR: begin
            O_addr    = P_OAM_DATA;
            O_wr_data = latch;
            O_rdwr    = 1'b0;
         end
         S_DMC_RD: begin
            O_addr    = I_dmc_addr;
            O_wr_data = 8'h00;
            O_rdwr    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dma_arbiter : self-checking bench for dma_arbiter
// rev 1.0
// ============================================================================
module tb_dma_arbiter;

   localparam logic [15:0] IDLE_ADDR = 16'h8123;
   localparam logic [15:0] DMC_ADDR  = 16'hC000;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wr_data;
   logic        cpu_rdwr;
   logic [7:0]  rd_data;
   logic        dmc_req;
   logic [15:0] dmc_addr;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wr_data;
   logic        bus_rdwr;
   logic        cpu_ready;
   logic [7:0]  dmc_data;
   logic        dmc_ack;

   typedef struct {
      logic [15:0] addr;
      logic        rdwr;
      logic [7:0]  data;
   } bus_rec_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        rdwr;
      logic [15:0] e_addr;
      logic [7:0]  e_wdata;
      logic        e_rdwr;
      logic        e_ready;
   } vec_t;

   bus_rec_t   exp_q[$];
   logic [7:0] dmc_q[$];
   vec_t       vecs[8];

   int tests = 0;
   int fails = 0;
   int cyc_idx = 0;
   int stall_n = 0;
   int dummy_n = 0;
   int dmc_rd_n = 0;
   int wr_n = 0;
   int ack_n = 0;
   logic [15:0] last_rd;
   logic [15:0] s_addr;
   logic [7:0]  s_wdata;
   logic        s_rdwr;
   logic        s_ready;

   function automatic logic [7:0] mem_fn(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
   endfunction

   assign rd_data = mem_fn(bus_addr);

   always #5 clock = ~clock;

   dma_arbiter #(.P_TICKS(12), .P_OAM_TRIG(16'h4014), .P_OAM_DATA(16'h2004)) dut (
      .I_clock       (clock),
      .I_reset       (reset),
      .I_cpu_addr    (cpu_addr),
      .I_cpu_wr_data (cpu_wr_data),
      .I_cpu_rdwr    (cpu_rdwr),
      .I_rd_data     (rd_data),
      .I_dmc_req     (dmc_req),
      .I_dmc_addr    (dmc_addr),
      .O_addr        (bus_addr),
      .O_wr_data     (bus_wr_data),
      .O_rdwr        (bus_rdwr),
      .O_cpu_ready   (cpu_ready),
      .O_dmc_data    (dmc_data),
      .O_dmc_ack     (dmc_ack)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   // One CPU cycle: sample mid-cycle, score the bus, then check for an ack at the boundary.
   task automatic step_cycle();
      bus_rec_t e;
      repeat (6) @(posedge clock);
      @(negedge clock);
      s_addr  = bus_addr;
      s_wdata = bus_wr_data;
      s_rdwr  = bus_rdwr;
      s_ready = cpu_ready;
      if (!s_rdwr) wr_n++;
      if (s_ready) begin
         check("passthru", {s_addr, s_rdwr, s_wdata}, {cpu_addr, cpu_rdwr, cpu_wr_data});
      end else begin
         stall_n++;
         if (s_rdwr && s_addr == cpu_addr)
            dummy_n++;
         else if (s_rdwr && s_addr == dmc_addr)
            dmc_rd_n++;
         else if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dma_unexpected: actual addr %0h rdwr %0b, required no DMA access", s_addr, s_rdwr);
         end else begin
            e = exp_q.pop_front();
            check("dma_bus", {s_addr, s_rdwr, (s_rdwr ? 8'h00 : s_wdata)},
                  {e.addr, e.rdwr, (e.rdwr ? 8'h00 : e.data)});
            if (s_rdwr) last_rd = s_addr;
         end
      end
      repeat (6) @(posedge clock);
      #1;
      cyc_idx++;
      if (dmc_ack) begin
         ack_n++;
         if (dmc_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dmc_ack_unexpected: actual ack with %0h, required none", dmc_data);
         end else begin
            check("dmc_data", {24'h0, dmc_data}, {24'h0, dmc_q.pop_front()});
         end
      end
   endtask

   task automatic idle_core();
      cpu_addr    = IDLE_ADDR;
      cpu_wr_data = 8'h00;
      cpu_rdwr    = 1'b1;
   endtask

   task automatic trigger_oam(input logic [7:0] page, input int parity);
      if ((cyc_idx % 2) != parity) step_cycle();
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back('{addr: {page, 8'(i)}, rdwr: 1'b1, data: 8'h00});
         exp_q.push_back('{addr: 16'h2004, rdwr: 1'b0, data: mem_fn({page, 8'(i)})});
      end
      last_rd     = 16'h0000;
      cpu_addr    = 16'h4014;
      cpu_wr_data = page;
      cpu_rdwr    = 1'b0;
      step_cycle();
      idle_core();
   endtask

   task automatic run_oam(input logic [7:0] page, input int parity, input bit steal);
      int st0, du0, dm0, ak0, guard, exp_stall;
      st0 = stall_n; du0 = dummy_n; dm0 = dmc_rd_n; ak0 = ack_n;
      exp_stall = (parity == 0) ? 513 : 514;
      trigger_oam(page, parity);
      if (steal) begin
         exp_stall += 2;
         guard = 0;
         while (last_rd != {page, 8'h40} && guard < 600) begin
            step_cycle();
            guard++;
         end
         dmc_q.push_back(mem_fn(DMC_ADDR));
         dmc_req = 1'b1;
         guard = 0;
         while (ack_n == ak0 && guard < 20) begin
            step_cycle();
            guard++;
         end
         dmc_req = 1'b0;
      end
      guard = 0;
      do begin
         step_cycle();
         guard++;
      end while (!s_ready && guard < 700);
      check("oam_ready_back", {31'h0, s_ready}, 32'h1);
      check("oam_stall", stall_n - st0, exp_stall);
      check("oam_dummy", dummy_n - du0, ((parity == 0) ? 1 : 2) + (steal ? 1 : 0));
      check("oam_dmc_reads", dmc_rd_n - dm0, steal ? 1 : 0);
      check("oam_acks", ack_n - ak0, steal ? 1 : 0);
      check("oam_left", exp_q.size(), 0);
   endtask

   task automatic run_dmc(input int parity);
      int st0, du0, dm0, ak0, guard;
      if ((cyc_idx % 2) != parity) step_cycle();
      st0 = stall_n; du0 = dummy_n; dm0 = dmc_rd_n; ak0 = ack_n;
      dmc_q.push_back(mem_fn(DMC_ADDR));
      dmc_req = 1'b1;
      guard = 0;
      while (ack_n == ak0 && guard < 10) begin
         step_cycle();
         guard++;
      end
      dmc_req = 1'b0;
      guard = 0;
      do begin
         step_cycle();
         guard++;
      end while (!s_ready && guard < 10);
      step_cycle();
      check("dmc_ready_back", {31'h0, s_ready}, 32'h1);
      check("dmc_stall", stall_n - st0, (parity == 0) ? 2 : 3);
      check("dmc_dummy", dummy_n - du0, (parity == 0) ? 0 + 1 : 2);
      check("dmc_reads", dmc_rd_n - dm0, 1);
      check("dmc_acks", ack_n - ak0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int guard, st0, wr0;
      reset    = 1'b1;
      dmc_req  = 1'b0;
      dmc_addr = DMC_ADDR;
      last_rd  = 16'h0000;
      cpu_addr = 16'h1234; cpu_wr_data = 8'h5C; cpu_rdwr = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_ready", {31'h0, cpu_ready}, 32'h1);
      check("rst_ack", {31'h0, dmc_ack}, 32'h0);
      check("rst_dmc_data", {24'h0, dmc_data}, 32'h0);
      check("rst_bus", {bus_addr, bus_wr_data, bus_rdwr}, {16'h1234, 8'h5C, 1'b0});
      #1 reset = 1'b0;
      cyc_idx = 0;

      vecs[0] = '{16'h0000, 8'h11, 1'b1, 16'h0000, 8'h11, 1'b1, 1'b1};
      vecs[1] = '{16'h0200, 8'h22, 1'b0, 16'h0200, 8'h22, 1'b0, 1'b1};
      vecs[2] = '{16'h4014, 8'h02, 1'b1, 16'h4014, 8'h02, 1'b1, 1'b1};
      vecs[3] = '{16'h4015, 8'h0F, 1'b0, 16'h4015, 8'h0F, 1'b0, 1'b1};
      vecs[4] = '{16'h2004, 8'hA7, 1'b0, 16'h2004, 8'hA7, 1'b0, 1'b1};
      vecs[5] = '{16'h4013, 8'h14, 1'b0, 16'h4013, 8'h14, 1'b0, 1'b1};
      vecs[6] = '{16'hFFFC, 8'h00, 1'b1, 16'hFFFC, 8'h00, 1'b1, 1'b1};
      vecs[7] = '{16'h8123, 8'h3E, 1'b1, 16'h8123, 8'h3E, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
         cpu_addr    = vecs[i].addr;
         cpu_wr_data = vecs[i].wdata;
         cpu_rdwr    = vecs[i].rdwr;
         step_cycle();
         check("vec", {s_addr, s_wdata, s_rdwr, s_ready},
               {vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_rdwr, vecs[i].e_ready});
      end
      for (int i = 0; i < 6; i++) begin
         cpu_addr    = 16'($urandom_range(0, 16'h3FFF));
         cpu_wr_data = 8'($urandom_range(0, 255));
         cpu_rdwr    = 1'($urandom_range(0, 1));
         step_cycle();
      end
      idle_core();

      run_oam(8'h02, 0, 1'b0);
      run_oam(8'h02, 1, 1'b0);
      run_oam(8'h05, 0, 1'b1);
      run_dmc(0);
      run_dmc(1);

      trigger_oam(8'h03, 0);
      guard = 0;
      while (last_rd != 16'h0380 && guard < 600) begin
         step_cycle();
         guard++;
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("mid_rst_ready", {31'h0, cpu_ready}, 32'h1);
      check("mid_rst_bus", {bus_addr, bus_rdwr}, {IDLE_ADDR, 1'b1});
      exp_q.delete();
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1 reset = 1'b0;
      cyc_idx = 0;
      st0 = stall_n;
      wr0 = wr_n;
      repeat (40) step_cycle();
      check("post_rst_stall", stall_n - st0, 0);
      check("post_rst_writes", wr_n - wr0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
